// File: rtl/pipe_pkg.sv
// Shared definitions for the MEM/WB elastic stage: FSM encoding, default widths
// and the packed entry layout {pc, instr, wd, we, waddr} (MSB to LSB).
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  function automatic int entry_w(input int data_w, input int addr_w);
    return PC_W + INSTR_W + data_w + 1 + addr_w;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: valid bit plus packed payload, with load and clear.
// Clear wins over load so a flush can never be undone by a same-cycle capture.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/mem_wb_elastic.sv
// MEM/WB stage with a two-entry skid buffer, flush, retire counter and a
// qualified forwarding write-enable for the hazard unit and register file.
//
// state    | meaning
// ST_EMPTY | no entry held
// ST_ONE   | main slot valid, skid empty
// ST_TWO   | main and skid valid, upstream stalled
module mem_wb_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_wd,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_waddr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_wd,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_waddr,
  output logic              fwd_we,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam int EW = entry_w(DATA_W, ADDR_W);

  state_e            state_q;
  logic              in_ready_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              main_valid, skid_valid;
  logic [EW-1:0]     main_q, skid_q, main_d, in_entry;
  logic              in_fire, out_fire;
  logic              main_load, main_clr, skid_load, skid_clr;

  assign in_entry = {in_pc, in_instr, in_wd, in_we, in_waddr};
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_valid & out_ready;

  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_d    = in_entry;
    case (state_q)
      ST_EMPTY: main_load = in_fire;
      ST_ONE: begin
        if (in_fire && out_fire)  main_load = 1'b1;
        else if (in_fire)         skid_load = 1'b1;
        else if (out_fire)        main_clr  = 1'b1;
      end
      ST_TWO: begin
        if (out_fire && skid_valid) begin
          main_load = 1'b1;
          main_d    = skid_q;
          skid_clr  = 1'b1;
        end
      end
      default: begin
        main_clr = 1'b1;
        skid_clr = 1'b1;
      end
    endcase
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      if (out_fire && !flush) cnt_q <= cnt_q + 1'b1;
      if (flush) begin
        state_q    <= ST_EMPTY;
        in_ready_q <= 1'b1;
      end else begin
        case (state_q)
          ST_EMPTY: if (in_fire) state_q <= ST_ONE;
          ST_ONE: begin
            if (in_fire && !out_fire) begin
              state_q    <= ST_TWO;
              in_ready_q <= 1'b0;
            end else if (!in_fire && out_fire) begin
              state_q <= ST_EMPTY;
            end
          end
          ST_TWO: begin
            if (out_fire) begin
              state_q    <= ST_ONE;
              in_ready_q <= 1'b1;
            end
          end
          default: begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  pipe_slot #(.W(EW)) u_main (
    .clk     (clk),
    .rst_n_i (reset),
    .clr_i   (main_clr),
    .load_i  (main_load),
    .d_i     (main_d),
    .valid_o (main_valid),
    .q_o     (main_q)
  );

  pipe_slot #(.W(EW)) u_skid (
    .clk     (clk),
    .rst_n_i (reset),
    .clr_i   (skid_clr),
    .load_i  (skid_load),
    .d_i     (in_entry),
    .valid_o (skid_valid),
    .q_o     (skid_q)
  );

  assign {out_pc, out_instr, out_wd, out_we, out_waddr} = main_q;
  assign out_valid  = main_valid;
  assign in_ready   = in_ready_q;
  assign fwd_we     = main_valid & out_we & (|out_waddr);
  assign retire_cnt = cnt_q;

endmodule

// File: doc/mem_wb_elastic.md
# mem_wb_elastic

Parametrised MEM/WB pipeline stage register with elastic valid/ready handshake, two-entry skid buffer, flush, and a retire counter. Sits between the memory stage and the register-file write port. Unlike the fixed register stage, it holds data under back-pressure without losing an entry. It also drives a qualified forwarding/write-back tuple consumed by the hazard unit and the GRF.

## Interface
- DATA_W, 32, write-back data width
- ADDR_W, 5, register address width
- CNT_W, 32, retire counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; reset == 0 at a rising edge clears all state
- flush  in  1  discard all held entries this cycle (exception/eret)
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_pc  in  32  instruction PC
- in_instr  in  32  instruction word
- in_wd  in  DATA_W  write-back data
- in_we  in  1  register write enable (pre-decoded upstream)
- in_waddr  in  ADDR_W  destination register
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_pc, out_instr, out_wd, out_we, out_waddr  out  as inputs  main entry fields
- fwd_we  out  1  out_valid & out_we & (out_waddr != 0)
- retire_cnt  out  CNT_W  count of completed output handshakes

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage consists of a main slot, which drives the out_* ports, and a skid slot. Each slot has a valid bit.
- States: EMPTY (no slot valid), ONE (main valid), TWO (main and skid valid).
- EMPTY: on in_fire, main <= in and the state moves to ONE.
- ONE:
  - in_fire & out_fire: main <= in; stay in ONE.
  - in_fire & !out_fire: skid <= in; go to TWO.
  - out_fire only: go to EMPTY.
  - Otherwise: hold.
- TWO: in_ready = 0. On out_fire, main <= skid and the state moves to ONE. Otherwise hold.
- Ordering is strictly FIFO. An entry is never duplicated or dropped except by flush.
- flush has priority over every handshake in the same cycle:
  - The state goes to EMPTY and both valid bits clear.
  - Concurrent in_fire and out_fire are ignored: the entry is not captured, and retire_cnt does not increment.
- Payload fields of an invalid slot are don't-care for the design. The bench compares them only when the slot is valid.
- retire_cnt increments by 1 on each out_fire without flush. It wraps modulo 2^CNT_W.
- fwd_we is combinational from the main slot. It is 0 whenever out_valid is 0, and 0 when the destination is $0.
- reset takes precedence over flush. A reset in the middle of operation, including in state TWO, drops all entries immediately.

## Timing
- Latency is 1 cycle: an entry accepted at edge N appears on out_* after edge N.
- Throughput is 1 entry/cycle while out_ready = 1.
- Under back-pressure, at most 2 entries are held. in_ready falls 1 cycle after the second entry is accepted.
- in_ready and out_valid are pure register outputs. There are no combinational paths from in_valid or out_ready to any output.
- Reset values: out_valid = 0, in_ready = 1, retire_cnt = 0, all out_* payload = 0, fwd_we = 0, state = EMPTY.
- After flush, the first cycle has out_valid = 0 and in_ready = 1.

## Structure
- Shared package pipe_pkg holds:
  - the state encoding (ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2);
  - the default widths (DATA_W = 32, ADDR_W = 5);
  - the entry field layout: PC, instr, wd, we, waddr.
- Sub-module pipe_slot: one entry register, consisting of a valid bit plus a packed payload, with load and clear controls. It is instantiated twice, as main and skid.
- Top level contains the state machine, the handshake logic, the retire counter and the fwd_we logic.

## Test plan
- Reset: hold reset = 0 for 2 cycles with in_valid = 1.
  - Required: out_valid = 0, in_ready = 1, retire_cnt = 0, fwd_we = 0.
- Streaming: out_ready = 1; drive 4 entries with PC 0x3000, 0x3004, 0x3008, 0x300C and wd = PC + 1.
  - Required: they emerge in order, 1 cycle later, back to back.
  - Required: retire_cnt = 4.
- Back-pressure: out_ready = 0; offer 3 entries with PC 0x3000, 0x3004, 0x3008.
  - Required: the first two are accepted, then in_ready = 0.
  - Required: with out_ready = 1, 0x3000 then 0x3004 emerge, then 0x3008 is accepted.
- Flush in TWO: with 2 entries held, assert flush together with in_valid = 1 and out_ready = 1.
  - Required next cycle: out_valid = 0, in_ready = 1, retire_cnt unchanged.
- Forwarding qualifier:
  - Entry we = 1, waddr = 0 → fwd_we = 0.
  - Entry we = 1, waddr = 5, wd = 0xDEADBEEF → fwd_we = 1 and out_wd = 0xDEADBEEF.
  - Entry we = 0, waddr = 5 → fwd_we = 0.
- Counter wrap: with CNT_W = 4, perform 17 handshakes.
  - Required: retire_cnt = 1.
  - Required: asserting reset = 0 mid-stream clears retire_cnt to 0.
